// File: rtl/data_mem_access.sv
// Multi-cycle load/store unit: turns a decoder MemRead/MemWrite into one req/ack
// bus transaction, stalls the core meanwhile, and formats half-word lanes.
module data_mem_access #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              half,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               half_q, a1_q, err_q;
  logic               start, misaligned, timeout;

  function automatic logic [31:0] fmt_load(input logic h, input logic a1,
                                           input logic [31:0] d);
    logic signed [15:0] hw;
    if (!h) return d;
    hw = a1 ? d[31:16] : d[15:0];
    return {{16{hw[15]}}, hw};
  endfunction

  assign start      = MemRead | MemWrite;
  assign misaligned = half ? addr[0] : (addr[1:0] != 2'b00);
  assign timeout    = (cnt == CNT_W'(TIMEOUT - 1)) && !mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || timeout) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign err = done & err_q;

  // Request latch in IDLE; completion capture in REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      half_q    <= 1'b0;
      a1_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            half_q    <= half;
            a1_q      <= addr[1];
            mem_we    <= MemWrite;
            err_q     <= misaligned;
            mem_addr  <= addr[ADDR_W-1:2];
            mem_be    <= half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            mem_wdata <= half ? {wr_data[15:0], wr_data[15:0]} : wr_data;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            err_q <= 1'b0;
            if (!mem_we) rd_data <= fmt_load(half_q, a1_q, mem_rdata);
          end else if (timeout) begin
            err_q <= 1'b1;
            if (!mem_we) rd_data <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: lanes, sign extension, misalignment,
// timeout and asynchronous reset behaviour.
module tb_data_mem_access;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              MemRead = 1'b0, MemWrite = 1'b0, half = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wr_data = '0;
  logic              stall, done, err, mem_req, mem_we;
  logic [31:0]       rd_data, mem_wdata;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  data_mem_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .half(half), .addr(addr), .wr_data(wr_data), .stall(stall), .done(done),
    .err(err), .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, done, err, mem_req, mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 00000", {stall, done, err, mem_req, mem_we});
    end
    checks++;
    if (rd_data !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || mem_addr !== '0) begin
      errors++; $display("FAIL reset_data: got rd=%h be=%b wd=%h ad=%h required zeros", rd_data, mem_be, mem_wdata, mem_addr);
    end
    reset = 1'b1;
  endtask

  task automatic test_word_read();
    @(negedge clk);
    MemRead = 1'b1; half = 1'b0; addr = 9'h010;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL wr_comb_stall: got %b required 1", stall); end
    @(negedge clk); MemRead = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 7'h04 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_bus: got req=%b addr=%h be=%b we=%b required 1 04 1111 0", mem_req, mem_addr, mem_be, mem_we);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || done !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL wr_wait: got req=%b done=%b stall=%b required 1 0 1", mem_req, done, stall);
    end
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 32'hDEADBEEF || mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL wr_done: got done=%b err=%b rd=%h req=%b stall=%b required 1 0 deadbeef 0 0", done, err, rd_data, mem_req, stall);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_half_read();
    logic [ADDR_W-1:0] a_tbl [2];
    logic [3:0]        be_tbl [2];
    logic [31:0]       rd_tbl [2];
    a_tbl = '{9'h022, 9'h020};
    be_tbl = '{4'b1100, 4'b0011};
    rd_tbl = '{32'hFFFF8001, 32'h00007FFF};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      MemRead = 1'b1; half = 1'b1; addr = a_tbl[i];
      @(negedge clk); MemRead = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_be !== be_tbl[i]) begin
        errors++; $display("FAIL hr_be[%0d]: got req=%b be=%b required 1 %b", i, mem_req, mem_be, be_tbl[i]);
      end
      mem_ack = 1'b1; mem_rdata = 32'h80017FFF;
      @(negedge clk); mem_ack = 1'b0;
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || rd_data !== rd_tbl[i]) begin
        errors++; $display("FAIL hr_data[%0d]: got done=%b err=%b rd=%h required 1 0 %h", i, done, err, rd_data, rd_tbl[i]);
      end
    end
  endtask

  task automatic test_half_write();
    @(negedge clk);
    MemWrite = 1'b1; half = 1'b1; addr = 9'h006; wr_data = 32'h1234ABCD;
    @(negedge clk); MemWrite = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 7'h01) begin
      errors++; $display("FAIL hw_bus: got req=%b we=%b be=%b wd=%h ad=%h required 1 1 1100 abcdabcd 01", mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk); mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 32'h00007FFF) begin
      errors++; $display("FAIL hw_done: got done=%b err=%b rd=%h required 1 0 00007fff", done, err, rd_data);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    MemRead = 1'b1; half = 1'b0; addr = 9'h013;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mis_stall: got %b required 1", stall); end
    @(negedge clk); MemRead = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0 || rd_data !== 32'h00007FFF) begin
      errors++; $display("FAIL mis_done: got done=%b err=%b req=%b rd=%h required 1 1 0 00007fff", done, err, mem_req, rd_data);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL mis_after: got req=%b done=%b err=%b required 0 0 0", mem_req, done, err);
    end
  endtask

  task automatic test_timeout();
    int n_req = 0;
    bit seen = 1'b0;
    @(negedge clk);
    MemRead = 1'b1; half = 1'b0; addr = 9'h000;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); MemRead = 1'b0;
      if (mem_req === 1'b1) n_req++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL to_done: got no done within 100 cycles, required done"); end
    checks++;
    if (n_req != TIMEOUT) begin errors++; $display("FAIL to_req_len: got %0d required %0d", n_req, TIMEOUT); end
    checks++;
    if (err !== 1'b1 || rd_data !== 32'h0) begin
      errors++; $display("FAIL to_result: got err=%b rd=%h required 1 00000000", err, rd_data);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    MemRead = 1'b1; half = 1'b0; addr = 9'h004;
    @(negedge clk); MemRead = 1'b0;
    mem_rdata = 32'h11112222;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre: got req=%b required 1", mem_req); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL rst_async: got req=%b stall=%b done=%b rd=%h required 0 0 0 0", mem_req, stall, done, rd_data);
    end
    @(negedge clk); reset = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL stray_ack: got req=%b done=%b stall=%b rd=%h required 0 0 0 0", mem_req, done, stall, rd_data);
    end
    MemWrite = 1'b1; half = 1'b0; addr = 9'h008; wr_data = 32'hCAFEF00D;
    @(negedge clk); MemWrite = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 7'h02) begin
      errors++; $display("FAIL post_wr_bus: got req=%b we=%b be=%b wd=%h ad=%h required 1 1 1111 cafef00d 02", mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL post_wr_done: got done=%b err=%b rd=%h required 1 0 00000000", done, err, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_half_read();
    test_half_write();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
